// File: rtl/fence_pkg.sv
// Shared widths, EMPTY accumulator constants and the published box record
// for the colour-mask box tracker.
package fence_pkg;
    localparam int COORD_X_W = 12;
    localparam int COORD_Y_W = 11;
    localparam int HCOUNT_W  = 11;
    localparam int VCOUNT_W  = 10;
    localparam int CNT_W     = 21;

    localparam logic [HCOUNT_W-1:0] EMPTY_XMIN = '1;
    localparam logic [VCOUNT_W-1:0] EMPTY_YMIN = '1;

    typedef struct packed {
        logic [COORD_X_W-1:0] x;
        logic [COORD_Y_W-1:0] y;
        logic [COORD_X_W-1:0] xmax;
        logic [COORD_Y_W-1:0] ymax;
    } bbox_t;

    // Rounded mean, used when blending a new box into the previous one.
    function automatic logic [COORD_X_W-1:0] avg_x(input logic [COORD_X_W-1:0] a,
                                                   input logic [COORD_X_W-1:0] b);
        logic [COORD_X_W:0] s;
        s = {1'b0, a} + {1'b0, b} + (COORD_X_W+1)'(1);
        return s[COORD_X_W:1];
    endfunction

    function automatic logic [COORD_Y_W-1:0] avg_y(input logic [COORD_Y_W-1:0] a,
                                                   input logic [COORD_Y_W-1:0] b);
        logic [COORD_Y_W:0] s;
        s = {1'b0, a} + {1'b0, b} + (COORD_Y_W+1)'(1);
        return s[COORD_Y_W:1];
    endfunction
endpackage

// File: rtl/bbox_tracker_if.sv
// Pixel stream in, published box out; master drives the stream.
interface bbox_if;
    import fence_pkg::*;
    logic                 pixel_valid_in;
    logic [HCOUNT_W-1:0]  hcount_in;
    logic [VCOUNT_W-1:0]  vcount_in;
    logic                 mask_in;
    logic                 frame_end_in;
    logic [COORD_X_W-1:0] x_out;
    logic [COORD_Y_W-1:0] y_out;
    logic [COORD_X_W-1:0] xmax_out;
    logic [COORD_Y_W-1:0] ymax_out;
    logic                 box_valid_out;
    logic                 box_update_out;

    modport master (output pixel_valid_in, hcount_in, vcount_in, mask_in, frame_end_in,
                    input  x_out, y_out, xmax_out, ymax_out, box_valid_out, box_update_out);
    modport slave  (input  pixel_valid_in, hcount_in, vcount_in, mask_in, frame_end_in,
                    output x_out, y_out, xmax_out, ymax_out, box_valid_out, box_update_out);
endinterface

// File: rtl/bbox_axis_accum.sv
// One axis min/max accumulator. min_eff/max_eff include the current-cycle hit
// so a snapshot taken on reload still sees it.
module bbox_axis_accum #(
    parameter int           W         = 11,
    parameter logic [W-1:0] EMPTY_MIN = '1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         hit,
    input  logic         reload,
    input  logic [W-1:0] coord,
    output logic [W-1:0] min_eff,
    output logic [W-1:0] max_eff
);
    logic [W-1:0] min_q, max_q;

    assign min_eff = (hit && coord < min_q) ? coord : min_q;
    assign max_eff = (hit && coord > max_q) ? coord : max_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            min_q <= EMPTY_MIN;
            max_q <= '0;
        end else if (reload) begin
            min_q <= EMPTY_MIN;
            max_q <= '0;
        end else begin
            min_q <= min_eff;
            max_q <= max_eff;
        end
    end
endmodule

// File: rtl/bbox_tracker.sv
// Per-frame bounding box: S0 snapshot, S1 centre compute, S2 publish.
// Optional BBOX_SMOOTH_EN blends each valid result with the previous one.
module bbox_tracker
    import fence_pkg::*;
#(
    parameter int MIN_PIXELS = 32,
    parameter int H_ACTIVE   = 1280,
    parameter int V_ACTIVE   = 720
) (
    input logic  clk_in,
    input logic  rst_n_in,
    bbox_if.slave bus
);
    localparam logic [HCOUNT_W-1:0] H_LIM   = HCOUNT_W'(H_ACTIVE);
    localparam logic [VCOUNT_W-1:0] V_LIM   = VCOUNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0]    MIN_CNT = CNT_W'(MIN_PIXELS);

    logic                hit, fend;
    logic [HCOUNT_W-1:0] xmin_eff, xmax_eff, s0_xmin, s0_xmax;
    logic [VCOUNT_W-1:0] ymin_eff, ymax_eff, s0_ymin, s0_ymax;
    logic [CNT_W-1:0]    cnt_q, cnt_eff, s0_cnt;
    logic [2:0]          vld_pipe;
    logic [COORD_X_W:0]  xsum;
    logic [COORD_Y_W:0]  ysum;
    bbox_t               s1_box, box_q, pub;
    logic                s1_ok, valid_q;

    assign fend = bus.frame_end_in;
    assign hit  = bus.pixel_valid_in && bus.mask_in &&
                  (bus.hcount_in < H_LIM) && (bus.vcount_in < V_LIM);
    assign cnt_eff = (hit && !(&cnt_q)) ? cnt_q + CNT_W'(1) : cnt_q;

    bbox_axis_accum #(.W(HCOUNT_W), .EMPTY_MIN(EMPTY_XMIN)) u_x (
        .clk(clk_in), .rst_n(rst_n_in), .hit(hit), .reload(fend),
        .coord(bus.hcount_in), .min_eff(xmin_eff), .max_eff(xmax_eff));

    bbox_axis_accum #(.W(VCOUNT_W), .EMPTY_MIN(EMPTY_YMIN)) u_y (
        .clk(clk_in), .rst_n(rst_n_in), .hit(hit), .reload(fend),
        .coord(bus.vcount_in), .min_eff(ymin_eff), .max_eff(ymax_eff));

    assign xsum = (COORD_X_W+1)'(s0_xmin) + (COORD_X_W+1)'(s0_xmax);
    assign ysum = (COORD_Y_W+1)'(s0_ymin) + (COORD_Y_W+1)'(s0_ymax);

    always_comb begin
        pub = s1_box;
`ifdef BBOX_SMOOTH_EN
        // Blend only onto a valid previous box; otherwise load directly.
        if (valid_q) begin
            pub.x    = avg_x(box_q.x,    s1_box.x);
            pub.y    = avg_y(box_q.y,    s1_box.y);
            pub.xmax = avg_x(box_q.xmax, s1_box.xmax);
            pub.ymax = avg_y(box_q.ymax, s1_box.ymax);
        end
`endif
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            cnt_q    <= '0;
            vld_pipe <= '0;
            s0_xmin  <= EMPTY_XMIN;
            s0_xmax  <= '0;
            s0_ymin  <= EMPTY_YMIN;
            s0_ymax  <= '0;
            s0_cnt   <= '0;
            s1_box   <= '0;
            s1_ok    <= 1'b0;
            box_q    <= '0;
            valid_q  <= 1'b0;
        end else begin
            vld_pipe <= {vld_pipe[1:0], fend};
            cnt_q    <= fend ? '0 : cnt_eff;
            if (fend) begin
                s0_xmin <= xmin_eff;
                s0_xmax <= xmax_eff;
                s0_ymin <= ymin_eff;
                s0_ymax <= ymax_eff;
                s0_cnt  <= cnt_eff;
            end
            s1_box.x    <= xsum[COORD_X_W:1];
            s1_box.y    <= ysum[COORD_Y_W:1];
            s1_box.xmax <= COORD_X_W'(s0_xmax);
            s1_box.ymax <= COORD_Y_W'(s0_ymax);
            s1_ok       <= (s0_cnt >= MIN_CNT);
            // Too few hits: flag invalid but keep the last good coordinates.
            if (vld_pipe[1]) begin
                valid_q <= s1_ok;
                if (s1_ok) box_q <= pub;
            end
        end
    end

    assign bus.x_out          = box_q.x;
    assign bus.y_out          = box_q.y;
    assign bus.xmax_out       = box_q.xmax;
    assign bus.ymax_out       = box_q.ymax;
    assign bus.box_valid_out  = valid_q;
    assign bus.box_update_out = vld_pipe[2];
endmodule

// File: tb/tb_bbox_tracker.sv
// Directed bench for bbox_tracker; smoothing expectations follow BBOX_SMOOTH_EN.
module tb_bbox_tracker;
    import fence_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    bbox_if bus();
    bbox_tracker dut (.clk_in(clk), .rst_n_in(rst_n), .bus(bus));

    function automatic logic [46:0] obs();
        return {bus.x_out, bus.y_out, bus.xmax_out, bus.ymax_out, bus.box_valid_out};
    endfunction

    task automatic idle();
        bus.pixel_valid_in = 1'b0;
        bus.mask_in        = 1'b0;
        bus.frame_end_in   = 1'b0;
        bus.hcount_in      = '0;
        bus.vcount_in      = '0;
    endtask

    task automatic drive(input bit pv, input bit m, input int h, input int v, input bit fe);
        bus.pixel_valid_in = pv;
        bus.mask_in        = m;
        bus.hcount_in      = HCOUNT_W'(h);
        bus.vcount_in      = VCOUNT_W'(v);
        bus.frame_end_in   = fe;
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic send_box(input int x0, input int y0, input int x1, input int y1, input int n);
        drive(1, 1, x0, y0, 0);
        drive(1, 1, x1, y1, 0);
        for (int i = 0; i < n - 2; i++)
            drive(1, 1, x0 + i % (x1 - x0 + 1), y0 + i % (y1 - y0 + 1), 0);
    endtask

    // Returns the negedge index (1-based) at which an update pulse is seen, 99 on timeout.
    task automatic wait_upd(output int n);
        n = 99;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (bus.box_update_out === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        int seen;
        idle();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_chk++;
        if (obs() !== 47'd0) begin
            n_fail++; $display("FAIL reset_outputs got %h exp %h", obs(), 47'd0);
        end
        n_chk++;
        if (bus.box_update_out !== 1'b0) begin
            n_fail++; $display("FAIL reset_update got %b exp 0", bus.box_update_out);
        end
        rst_n = 1'b1;
        // Empty frame straight after reset: invalid, coordinates stay 0.
        drive(0, 0, 0, 0, 1);
        wait_upd(seen);
        n_chk++;
        if (seen !== 3 || obs() !== 47'd0) begin
            n_fail++; $display("FAIL reset_empty_frame got lat=%0d box=%h exp lat=3 box=0", seen, obs());
        end
    endtask

    task automatic test_basic();
        int seen;
        logic [46:0] exp_b;
        exp_b = {12'd200, 11'd125, 12'd300, 11'd200, 1'b1};
        send_box(100, 50, 300, 200, 32);
        drive(0, 0, 0, 0, 1);
        wait_upd(seen);
        n_chk++;
        if (seen !== 3) begin
            n_fail++; $display("FAIL basic_latency got %0d exp 3", seen);
        end
        n_chk++;
        if (obs() !== exp_b) begin
            n_fail++; $display("FAIL basic_box got %h exp %h", obs(), exp_b);
        end
        @(negedge clk);
        n_chk++;
        if (bus.box_update_out !== 1'b0) begin
            n_fail++; $display("FAIL basic_single_pulse got %b exp 0", bus.box_update_out);
        end
    endtask

    task automatic test_min_pixels();
        int seen;
        logic [46:0] exp_b;
        exp_b = {12'd200, 11'd125, 12'd300, 11'd200, 1'b0};
        send_box(10, 10, 40, 10, 31);
        drive(0, 0, 0, 0, 1);
        wait_upd(seen);
        n_chk++;
        if (seen !== 3 || obs() !== exp_b) begin
            n_fail++; $display("FAIL min_pixels got lat=%0d box=%h exp lat=3 box=%h", seen, obs(), exp_b);
        end
    endtask

    task automatic test_coincident();
        int seen;
        logic [46:0] exp_b;
        exp_b = {12'd620, 11'd330, 12'd640, 11'd360, 1'b1};
        send_box(600, 300, 630, 300, 31);
        drive(1, 1, 640, 360, 1);
        wait_upd(seen);
        n_chk++;
        if (seen !== 3 || obs() !== exp_b) begin
            n_fail++; $display("FAIL coincident_hit got lat=%0d box=%h exp lat=3 box=%h", seen, obs(), exp_b);
        end
        exp_b = {12'd620, 11'd330, 12'd640, 11'd360, 1'b0};
        drive(0, 0, 0, 0, 1);
        wait_upd(seen);
        n_chk++;
        if (seen !== 3 || obs() !== exp_b) begin
            n_fail++; $display("FAIL coincident_next_empty got lat=%0d box=%h exp lat=3 box=%h", seen, obs(), exp_b);
        end
    endtask

    task automatic test_back_to_back();
        int seen;
        logic [46:0] exp_a, exp_b;
        exp_a = {12'd15, 11'd0, 12'd31, 11'd0, 1'b1};
        exp_b = {12'd15, 11'd0, 12'd31, 11'd0, 1'b0};
        send_box(0, 0, 31, 0, 32);
        drive(0, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 1);
        wait_upd(seen);
        n_chk++;
        if (seen !== 2 || obs() !== exp_a) begin
            n_fail++; $display("FAIL b2b_first got lat=%0d box=%h exp lat=2 box=%h", seen, obs(), exp_a);
        end
        @(negedge clk);
        n_chk++;
        if (bus.box_update_out !== 1'b1 || obs() !== exp_b) begin
            n_fail++; $display("FAIL b2b_second got upd=%b box=%h exp upd=1 box=%h", bus.box_update_out, obs(), exp_b);
        end
        @(negedge clk);
        n_chk++;
        if (bus.box_update_out !== 1'b0) begin
            n_fail++; $display("FAIL b2b_end got %b exp 0", bus.box_update_out);
        end
    endtask

    task automatic test_degenerate();
        int seen;
        logic [46:0] exp_b;
        exp_b = {12'd500, 11'd415, 12'd500, 11'd431, 1'b1};
        send_box(500, 400, 500, 431, 32);
        drive(0, 0, 0, 0, 1);
        wait_upd(seen);
        n_chk++;
        if (seen !== 3 || obs() !== exp_b) begin
            n_fail++; $display("FAIL degenerate got lat=%0d box=%h exp lat=3 box=%h", seen, obs(), exp_b);
        end
    endtask

    task automatic test_inactive();
        int seen;
        logic [46:0] exp_b;
        exp_b = {12'd500, 11'd415, 12'd500, 11'd431, 1'b0};
        for (int i = 0; i < 20; i++) drive(1, 1, 1280, 10 + i, 0);
        for (int i = 0; i < 20; i++) drive(1, 1, 10 + i, 720, 0);
        for (int i = 0; i < 10; i++) drive(1, 0, 5, 5, 0);
        for (int i = 0; i < 10; i++) drive(0, 1, 5, 5, 0);
        drive(0, 0, 0, 0, 1);
        wait_upd(seen);
        n_chk++;
        if (seen !== 3 || obs() !== exp_b) begin
            n_fail++; $display("FAIL inactive_area got lat=%0d box=%h exp lat=3 box=%h", seen, obs(), exp_b);
        end
    endtask

    task automatic test_reset_smooth();
        int seen, ups;
        logic [46:0] exp_b;
        send_box(100, 50, 300, 200, 32);
        drive(0, 0, 0, 0, 1);
        drive(1, 1, 5, 5, 0);
        // Result is one edge from publishing; reset must kill it.
        rst_n = 1'b0;
        #1;
        n_chk++;
        if (obs() !== 47'd0 || bus.box_update_out !== 1'b0) begin
            n_fail++; $display("FAIL midreset_clear got box=%h upd=%b exp box=0 upd=0", obs(), bus.box_update_out);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        ups = 0;
        repeat (4) begin
            @(negedge clk);
            if (bus.box_update_out === 1'b1) ups++;
        end
        n_chk++;
        if (ups !== 0 || obs() !== 47'd0) begin
            n_fail++; $display("FAIL midreset_no_pulse got pulses=%0d box=%h exp pulses=0 box=0", ups, obs());
        end
        drive(1, 1, 5, 5, 0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_b = {12'd200, 11'd125, 12'd300, 11'd200, 1'b1};
        send_box(100, 50, 300, 200, 32);
        drive(0, 0, 0, 0, 1);
        wait_upd(seen);
        n_chk++;
        if (seen !== 3 || obs() !== exp_b) begin
            n_fail++; $display("FAIL post_reset_first got lat=%0d box=%h exp lat=3 box=%h", seen, obs(), exp_b);
        end
`ifdef BBOX_SMOOTH_EN
        exp_b = {12'd250, 11'd125, 12'd350, 11'd200, 1'b1};
`else
        exp_b = {12'd300, 11'd125, 12'd400, 11'd200, 1'b1};
`endif
        send_box(200, 50, 400, 200, 32);
        drive(0, 0, 0, 0, 1);
        wait_upd(seen);
        n_chk++;
        if (seen !== 3 || obs() !== exp_b) begin
            n_fail++; $display("FAIL second_box got lat=%0d box=%h exp lat=3 box=%h", seen, obs(), exp_b);
        end
    endtask

    initial begin
        idle();
        test_reset();
        test_basic();
        test_min_pixels();
        test_coincident();
        test_back_to_back();
        test_degenerate();
        test_inactive();
        test_reset_smooth();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
